// File: rtl/load_store_unit_pkg.sv
// Shared types for the load/store unit: funct3 encodings, FSM states and bus width.
package load_store_unit_pkg;

    localparam int unsigned DATA_BUS = 32;

    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd4,
        MEM_HU = 3'd5
    } mem_funct3_t;

    typedef enum logic {
        LSU_IDLE   = 1'b0,
        LSU_RMW_WR = 1'b1
    } lsu_state_t;

    function automatic logic [DATA_BUS-1:0] word_addr(input logic [DATA_BUS-1:0] a);
        return {a[DATA_BUS-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load data path: picks the byte/half/word lane from a RAM word and sign- or zero-extends it.
module load_extend
    import load_store_unit_pkg::*;
(
    input  logic [2:0]          funct3_i,
    input  logic [1:0]          addr_lo_i,
    input  logic [DATA_BUS-1:0] word_i,
    output logic [DATA_BUS-1:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = '0;
        case (addr_lo_i)
            2'd0:    byte_sel = word_i[7:0];
            2'd1:    byte_sel = word_i[15:8];
            2'd2:    byte_sel = word_i[23:16];
            default: byte_sel = word_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? word_i[31:16] : word_i[15:0];

        rdata_o = '0;
        case (mem_funct3_t'(funct3_i))
            MEM_B:   rdata_o = {{(DATA_BUS-8){byte_sel[7]}}, byte_sel};
            MEM_BU:  rdata_o = {{(DATA_BUS-8){1'b0}}, byte_sel};
            MEM_H:   rdata_o = {{(DATA_BUS-16){half_sel[15]}}, half_sel};
            MEM_HU:  rdata_o = {{(DATA_BUS-16){1'b0}}, half_sel};
            MEM_W:   rdata_o = word_i;
            default: rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store initiator for a word-only data RAM; sub-word stores use a read-modify-write pair.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter bit ADDR_LSB_CHECK = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [2:0]          funct3_i,
    input  logic [DATA_BUS-1:0] addr_i,
    input  logic [DATA_BUS-1:0] wdata_i,
    output logic [DATA_BUS-1:0] rdata_o,
    output logic                done_o,
    output logic                stall_o,
    output logic                err_o,
    output logic                mem_de_o,
    output logic                mem_we_o,
    output logic [DATA_BUS-1:0] mem_a_o,
    output logic [DATA_BUS-1:0] mem_wd_o,
    input  logic [DATA_BUS-1:0] mem_rd_i
);

    lsu_state_t          state_q, state_d;
    logic [DATA_BUS-1:0] merge_q, merge_d;
    logic [DATA_BUS-1:0] addr_q, addr_d;
    logic [DATA_BUS-1:0] ext_rdata;
    logic                legal_f3, misaligned, illegal, sub_word_store;

    load_extend u_load_extend (
        .funct3_i  (funct3_i),
        .addr_lo_i (addr_i[1:0]),
        .word_i    (mem_rd_i),
        .rdata_o   (ext_rdata)
    );

    always_comb begin
        legal_f3 = we_i ? (funct3_i inside {MEM_B, MEM_H, MEM_W})
                        : (funct3_i inside {MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU});
        misaligned = 1'b0;
        if (ADDR_LSB_CHECK) begin
            case (funct3_i[1:0])
                2'b01:   misaligned = addr_i[0];
                2'b10:   misaligned = |addr_i[1:0];
                default: misaligned = 1'b0;
            endcase
        end
        illegal        = !legal_f3 || misaligned;
        sub_word_store = we_i && (funct3_i != MEM_W);
    end

    // Merge the store lane into the word read this cycle; written back next cycle.
    always_comb begin
        merge_d = merge_q;
        addr_d  = addr_q;
        if (state_q == LSU_IDLE && req_i && !illegal && sub_word_store) begin
            addr_d  = word_addr(addr_i);
            merge_d = mem_rd_i;
            if (funct3_i[1:0] == 2'b00) begin
                case (addr_i[1:0])
                    2'd0:    merge_d[7:0]   = wdata_i[7:0];
                    2'd1:    merge_d[15:8]  = wdata_i[7:0];
                    2'd2:    merge_d[23:16] = wdata_i[7:0];
                    default: merge_d[31:24] = wdata_i[7:0];
                endcase
            end else if (addr_i[1]) begin
                merge_d[31:16] = wdata_i[15:0];
            end else begin
                merge_d[15:0] = wdata_i[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LSU_IDLE;
            merge_q <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            merge_q <= merge_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE:   if (req_i && !illegal && sub_word_store) state_d = LSU_RMW_WR;
            LSU_RMW_WR: state_d = LSU_IDLE;
            default:    state_d = LSU_IDLE;
        endcase
    end

    always_comb begin
        rdata_o  = '0;
        done_o   = 1'b0;
        stall_o  = 1'b0;
        err_o    = 1'b0;
        mem_de_o = 1'b0;
        mem_we_o = 1'b0;
        mem_a_o  = '0;
        mem_wd_o = '0;
        if (!rst) begin
            case (state_q)
                LSU_IDLE: begin
                    if (req_i && illegal) begin
                        done_o = 1'b1;
                        err_o  = 1'b1;
                    end else if (req_i && !we_i) begin
                        mem_de_o = 1'b1;
                        mem_a_o  = word_addr(addr_i);
                        rdata_o  = ext_rdata;
                        done_o   = 1'b1;
                    end else if (req_i && !sub_word_store) begin
                        mem_de_o = 1'b1;
                        mem_we_o = 1'b1;
                        mem_a_o  = word_addr(addr_i);
                        mem_wd_o = wdata_i;
                        done_o   = 1'b1;
                    end else if (req_i) begin
                        mem_de_o = 1'b1;
                        mem_a_o  = word_addr(addr_i);
                        stall_o  = 1'b1;
                    end
                end
                LSU_RMW_WR: begin
                    mem_de_o = 1'b1;
                    mem_we_o = 1'b1;
                    mem_a_o  = addr_q;
                    mem_wd_o = merge_q;
                    done_o   = 1'b1;
                    stall_o  = req_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed scenarios, then random traffic scored against a byte-level memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    logic [31:0] rdata_o, mem_a_o, mem_wd_o, mem_rd_i;
    logic        done_o, stall_o, err_o, mem_de_o, mem_we_o;

    int unsigned total = 0;
    int unsigned passed = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] ram [16];
    logic [31:0] ref_mem [16];
    logic        fill_en = 1'b0;
    logic        preset_en = 1'b0;
    logic [31:0] preset_val = '0;
    logic        mon_en = 1'b0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_LSB_CHECK(1'b1)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_i    (req),
        .we_i     (we),
        .funct3_i (f3),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .rdata_o  (rdata_o),
        .done_o   (done_o),
        .stall_o  (stall_o),
        .err_o    (err_o),
        .mem_de_o (mem_de_o),
        .mem_we_o (mem_we_o),
        .mem_a_o  (mem_a_o),
        .mem_wd_o (mem_wd_o),
        .mem_rd_i (mem_rd_i)
    );

    function automatic logic [31:0] init_word(input int unsigned i);
        return (i == 0) ? 32'hDEADBEEF : 32'(32'h9E3779B9 * (i + 1));
    endfunction

    // Data RAM: word-only, combinational read, write on posedge.
    assign mem_rd_i = ram[mem_a_o[5:2]];
    always @(posedge clk) begin
        if (fill_en) begin
            for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
        end else if (preset_en) begin
            ram[0] <= preset_val;
        end else if (mem_de_o && mem_we_o) begin
            ram[mem_a_o[5:2]] <= mem_wd_o;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic w, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; f3 = f; addr = a; wdata = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic dload(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] exp);
        drive(1'b1, 1'b0, f, a, 32'h0);
        @(negedge clk);
        chk({name, "_rdata"}, rdata_o, exp);
        chk({name, "_done"}, 32'({done_o, stall_o, err_o}), 32'b100);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
    endtask

    // Reference: RAM as an array of words, accesses computed from byte offsets and sizes.
    function automatic exp_t model(input logic w, input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t        e;
        int unsigned bytes, off, idx;
        logic [31:0] v, mask;
        logic        legal;
        bytes = (f[1:0] == 2'd0) ? 1 : (f[1:0] == 2'd1) ? 2 : 4;
        legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (a % bytes != 0) legal = 1'b0;
        off = a % 4;
        idx = (a - 32'h10000) / 4;
        e.rdata = 32'h0;
        e.err   = !legal;
        if (legal && !w) begin
            v = ref_mem[idx] >> (8 * off);
            if (bytes == 1) begin
                v = v & 32'hFF;
                if (f == 3'd0 && v >= 32'h80) v = v | 32'hFFFFFF00;
            end else if (bytes == 2) begin
                v = v & 32'hFFFF;
                if (f == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            e.rdata = v;
        end else if (legal && w) begin
            mask = (bytes == 4) ? 32'hFFFFFFFF : (bytes == 2) ? 32'hFFFF : 32'hFF;
            mask = mask << (8 * off);
            ref_mem[idx] = (ref_mem[idx] & ~mask) | ((d << (8 * off)) & mask);
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (mem_de_o) chk("mem_a_aligned", mem_a_o & ~32'h3C, 32'h10000);
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", 32'(done_o), 32'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("rand_rdata", rdata_o, e.rdata);
                    chk("rand_err", 32'(err_o), 32'(e.err));
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        logic s, dn;
        int   n;
        exp_q.push_back(model(w, f, a, d));
        drive(1'b1, w, f, a, d);
        n = 0;
        forever begin
            @(negedge clk);
            s  = stall_o;
            dn = done_o;
            cyc();
            if (!s || !dn) break;
            n++;
            if (n > 8) begin
                chk("stall_bound", 32'(stall_o), 32'h0);
                break;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 1'b0, 3'd2, 32'h10000, 32'h0);
        fill_en = 1'b1;
        cyc();
        fill_en = 1'b0;
        @(negedge clk);
        chk("reset_ctl", 32'({mem_de_o, mem_we_o, done_o, stall_o, err_o}), 32'h0);
        chk("reset_rdata", rdata_o, 32'h0);
        cyc();
        rst = 1'b0;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        dload("lb", 3'd0, 32'h10003, 32'hFFFFFFDE);
        dload("lbu", 3'd4, 32'h10003, 32'h000000DE);
        dload("lh", 3'd1, 32'h10002, 32'hFFFFDEAD);
        dload("lhu", 3'd5, 32'h10000, 32'h0000BEEF);

        drive(1'b1, 1'b1, 3'd0, 32'h10001, 32'h12345678);
        @(negedge clk);
        chk("sb_c0_ctl", 32'({mem_de_o, mem_we_o, stall_o, done_o}), 32'b1010);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("sb_c1_ctl", 32'({mem_de_o, mem_we_o, done_o}), 32'b111);
        chk("sb_c1_a", mem_a_o, 32'h10000);
        chk("sb_c1_wd", mem_wd_o, 32'hDEAD78EF);
        cyc();
        dload("lw_after_sb", 3'd2, 32'h10000, 32'hDEAD78EF);

        drive(1'b1, 1'b1, 3'd2, 32'h10000, 32'hDEADBEEF);
        @(negedge clk);
        chk("sw_restore_ctl", 32'({mem_de_o, mem_we_o, done_o, stall_o}), 32'b1110);
        cyc();
        drive(1'b1, 1'b1, 3'd1, 32'h10002, 32'hAAAA5555);
        @(negedge clk);
        chk("sh_c0_stall", 32'({stall_o, done_o}), 32'b10);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("sh_c1_wd", mem_wd_o, 32'h5555BEEF);
        cyc();

        drive(1'b1, 1'b1, 3'd2, 32'h10000, 32'h01020304);
        @(negedge clk);
        chk("sw_ctl", 32'({mem_de_o, mem_we_o, done_o, stall_o, err_o}), 32'b11100);
        chk("sw_wd", mem_wd_o, 32'h01020304);
        cyc();

        begin
            logic        ew [3] = '{1'b0, 1'b1, 1'b0};
            logic [2:0]  ef [3] = '{3'd2, 3'd1, 3'd3};
            logic [31:0] ea [3] = '{32'h10002, 32'h10001, 32'h10000};
            for (int i = 0; i < 3; i++) begin
                drive(1'b1, ew[i], ef[i], ea[i], 32'hFFFFFFFF);
                @(negedge clk);
                chk("err_ctl", 32'({err_o, done_o, mem_de_o, mem_we_o, stall_o}), 32'b11000);
                chk("err_rdata", rdata_o, 32'h0);
                cyc();
            end
        end
        dload("lw_after_err", 3'd2, 32'h10000, 32'h01020304);

        drive(1'b1, 1'b1, 3'd0, 32'h10000, 32'h000000FF);
        @(negedge clk);
        cyc();
        drive(1'b1, 1'b0, 3'd2, 32'h10000, 32'h0);
        @(negedge clk);
        chk("rmw_new_req_ctl", 32'({stall_o, done_o, mem_we_o}), 32'b111);
        cyc();
        @(negedge clk);
        chk("rmw_held_load_ctl", 32'({done_o, stall_o}), 32'b10);
        chk("rmw_held_load_rdata", rdata_o, 32'h010203FF);
        cyc();
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);

        preset_en = 1'b1;
        preset_val = 32'hDEADBEEF;
        cyc();
        preset_en = 1'b0;
        drive(1'b1, 1'b1, 3'd0, 32'h10000, 32'h00000011);
        @(negedge clk);
        cyc();
        rst = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_rmw_ctl", 32'({mem_de_o, mem_we_o, done_o}), 32'h0);
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rmw_ram", ram[0], 32'hDEADBEEF);
        chk("rst_rmw_idle", 32'({mem_de_o, mem_we_o, done_o, stall_o, err_o}), 32'h0);
        chk("rst_rmw_rdata", rdata_o, 32'h0);
        cyc();
        dload("lw_after_rst", 3'd2, 32'h10000, 32'hDEADBEEF);

        fill_en = 1'b1;
        cyc();
        fill_en = 1'b0;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        mon_en = 1'b1;
        for (int n = 0; n < 400; n++) begin
            logic        w;
            logic [2:0]  f;
            logic [31:0] a;
            w = 1'($urandom_range(0, 1));
            f = 3'($urandom_range(0, 7));
            a = 32'h10000 + $urandom_range(0, 63);
            issue(w, f, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
                repeat ($urandom_range(1, 2)) cyc();
            end
        end
        drive(1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cyc();
        cyc();
        chk("queue_drain", exp_q.size(), 32'h0);
        for (int i = 0; i < 16; i++) chk("ram_final", ram[i], ref_mem[i]);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
